// File: rtl/mul_arbiter.sv
// mul_arbiter: two-requester arbiter sharing one 32x32 signed multiplier.
// Optional macro MUL_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// when it is undefined, requester 0 has fixed priority.

// mul_32_b: combinational full-width signed 32x32 multiplier
module mul_32_b (
    input  logic signed [31:0] a,
    input  logic signed [31:0] b,
    output logic signed [63:0] z
);
    assign z = a * b;
endmodule

module mul_arbiter #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [1:0]  resp_valid,
    input  logic [1:0]  resp_ready,
    output logic [63:0] resp_z,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [3:0] CNT_MAX = 4'(LAT - 1);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic signed [31:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [63:0]        z_q, z_d;
    logic               id_q, id_d;
    logic signed [63:0] mul_z;
    logic               any_req;
    logic               gnt_id;

    assign any_req = |req_valid;

    mul_32_b u_mul (
        .a(op_a_q),
        .b(op_b_q),
        .z(mul_z)
    );

`ifdef MUL_ARB_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;

    assign gnt_id = (req_valid == 2'b11) ? ptr_q : req_valid[1];

    // pointer moves to the requester that lost (or did not compete) after each accept
    always_comb ptr_d = (state_q == IDLE && any_req) ? ~gnt_id : ptr_q;

    // round-robin pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end
`else
    assign gnt_id = ~req_valid[0];
`endif

    // next-state, operand capture and handshake outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        z_d       = z_q;
        id_d      = id_q;
        req_ready = 2'b00;
        case (state_q)
            IDLE: if (any_req) begin
                req_ready = gnt_id ? 2'b10 : 2'b01;
                op_a_d    = gnt_id ? req1_a : req0_a;
                op_b_d    = gnt_id ? req1_b : req0_b;
                id_d      = gnt_id;
                cnt_d     = '0;
                state_d   = CALC;
            end
            CALC: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_MAX) begin
                    z_d     = mul_z;
                    state_d = DONE;
                end
            end
            DONE: if (resp_ready[id_q]) begin
                z_d     = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_valid = (state_q == DONE) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
    assign resp_z     = z_q;
    assign busy       = state_q != IDLE;

    // state and datapath registers, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            z_q     <= '0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            z_q     <= z_d;
            id_q    <= id_d;
        end
    end
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: table-driven and scoreboard checks of mul_arbiter at LAT 2, 4, 1 and 8.
module tb_mul_arbiter;
    localparam int LATS [4] = '{2, 4, 1, 8};

    typedef struct packed {
        logic [1:0]  mask;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic        id;
        logic [63:0] z;
    } vec_t;

    typedef struct packed {
        logic        id;
        logic [63:0] z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  resp_ready = 2'b11;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]  rq [4];
    logic [1:0]  rv [4];
    logic [63:0] rz [4];
    logic        bz [4];

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   sel = 0;
    int   acc_cyc = 0;
    logic seen = 1'b0;
    exp_t q[$];
    vec_t tbl [8];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mul_arbiter #(.LAT(LATS[g])) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .req_valid(req_valid),
            .req_ready(rq[g]),
            .req0_a(a0),
            .req0_b(b0),
            .req1_a(a1),
            .req1_b(b1),
            .resp_valid(rv[g]),
            .resp_ready(resp_ready),
            .resp_z(rz[g]),
            .busy(bz[g])
        );
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [1:0] oh(logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick_s();
        @(negedge clk);
        #1;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
                continue;
            end
            if (rq[sel] != 2'b00) acc_cyc = cyc + 1;
            if (rv[sel] == 2'b00) chk("resp_z_idle", rz[sel], 64'd0);
            else if (!seen) begin
                seen = 1'b1;
                if (q.size() == 0) chk("spurious_resp", 64'(rv[sel]), 64'd0);
                else begin
                    chk("resp_valid", 64'(rv[sel]), 64'(oh(q[0].id)));
                    chk("resp_z", rz[sel], q[0].z);
                    chk("latency", 64'(cyc - acc_cyc), 64'(LATS[sel]));
                end
            end
            if (rv[sel] != 2'b00 && (rv[sel] & resp_ready) != 2'b00) begin
                if (q.size() > 0) void'(q.pop_front());
                seen = 1'b0;
            end
        end
    endtask

    task automatic do_reset(int s);
        sel = s;
        rst_n = 1'b0;
        req_valid = 2'b00;
        resp_ready = 2'b11;
        q.delete();
        tick_s();
        chk("rst_resp_valid", 64'(rv[sel]), 64'd0);
        chk("rst_resp_z", rz[sel], 64'd0);
        chk("rst_busy", 64'(bz[sel]), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_vec(vec_t v, string nm);
        int w;
        req_valid = v.mask;
        a0 = v.a0;
        b0 = v.b0;
        a1 = v.a1;
        b1 = v.b1;
        q.push_back('{v.id, v.z});
        w = 0;
        tick_s();
        while (rq[sel] == 2'b00 && w < 30) begin
            w++;
            tick_s();
        end
        chk({nm, "_ready"}, 64'(rq[sel]), 64'(oh(v.id)));
        chk({nm, "_wait"}, 64'(w), 64'd0);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        w = 0;
        while (q.size() != 0 && w < 40) begin
            tick_s();
            w++;
        end
        chk({nm, "_done"}, 64'(q.size()), 64'd0);
        q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int acc_prev;
        int acc;
        logic id;
        tbl[0] = '{2'b01, 32'd7, 32'hFFFFFFFD, 32'd5, 32'd5, 1'b0, 64'hFFFFFFFFFFFFFFEB};
        tbl[1] = '{2'b01, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 1'b0, 64'h4000000000000000};
        tbl[2] = '{2'b10, 32'd1, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001};
        tbl[3] = '{2'b01, 32'd0, 32'h12345678, 32'd9, 32'd9, 1'b0, 64'h0};
        tbl[4] = '{2'b10, 32'd3, 32'd3, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 64'h3FFFFFFF00000001};
        tbl[5] = '{2'b11, 32'h7FFFFFFF, 32'h80000000, 32'd100, 32'd200, 1'b0, 64'hC000000080000000};
`ifdef MUL_ARB_ROUND_ROBIN_EN
        tbl[6] = '{2'b11, 32'hFFFFFFFB, 32'd6, 32'd100, 32'd200, 1'b1, 64'h0000000000004E20};
`else
        tbl[6] = '{2'b11, 32'hFFFFFFFB, 32'd6, 32'd100, 32'd200, 1'b0, 64'hFFFFFFFFFFFFFFE2};
`endif
        tbl[7] = '{2'b10, 32'd2, 32'd2, 32'h00010000, 32'h00010000, 1'b1, 64'h0000000100000000};
        fork
            monitor();
        join_none

        do_reset(0);
        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        for (int s = 2; s < 4; s++) begin
            do_reset(s);
            for (int i = 0; i < 3; i++) run_vec(tbl[i], $sformatf("lat%0d_vec%0d", LATS[s], i));
        end

        do_reset(0);
        req_valid = 2'b11;
        a0 = 32'd3;
        b0 = 32'd4;
        a1 = 32'hFFFFFFFB;
        b1 = 32'd6;
        acc_prev = 0;
        for (int k = 0; k < 4; k++) begin
`ifdef MUL_ARB_ROUND_ROBIN_EN
            id = k[0];
`else
            id = 1'b0;
`endif
            q.push_back('{id, id ? 64'hFFFFFFFFFFFFFFE2 : 64'd12});
            w = 0;
            tick_s();
            while (rq[sel] == 2'b00 && w < 30) begin
                w++;
                tick_s();
            end
            acc = cyc + 1;
            chk($sformatf("contend%0d_ready", k), 64'(rq[sel]), 64'(oh(id)));
            if (k > 0) chk($sformatf("contend%0d_spacing", k), 64'(acc - acc_prev), 64'(LATS[0] + 2));
            acc_prev = acc;
            w = 0;
            while (q.size() != 0 && w < 40) begin
                tick_s();
                w++;
            end
            chk($sformatf("contend%0d_done", k), 64'(q.size()), 64'd0);
        end
        req_valid = 2'b00;
        @(posedge clk);
        #1;

        do_reset(0);
        resp_ready = 2'b10;
        req_valid = 2'b01;
        a0 = 32'd7;
        b0 = 32'hFFFFFFFD;
        q.push_back('{1'b0, 64'hFFFFFFFFFFFFFFEB});
        tick_s();
        chk("bp_accept0", 64'(rq[sel]), 64'h1);
        @(posedge clk);
        #1;
        req_valid = 2'b10;
        a1 = 32'd2;
        b1 = 32'd3;
        q.push_back('{1'b1, 64'd6});
        w = 0;
        tick_s();
        while (rv[sel] == 2'b00 && w < 20) begin
            w++;
            tick_s();
        end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold_valid%0d", i), 64'(rv[sel]), 64'h1);
            chk($sformatf("bp_hold_z%0d", i), rz[sel], 64'hFFFFFFFFFFFFFFEB);
            chk($sformatf("bp_blocked%0d", i), 64'(rq[sel]), 64'h0);
            if (i == 4) break;
            @(posedge clk);
            #1;
            if (i == 3) resp_ready = 2'b01;
            tick_s();
        end
        tick_s();
        chk("bp_accept1", 64'(rq[sel]), 64'h2);
        chk("bp_released", 64'(rv[sel]), 64'h0);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        resp_ready = 2'b11;
        w = 0;
        while (q.size() != 0 && w < 40) begin
            tick_s();
            w++;
        end
        chk("bp_done", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;

        do_reset(1);
        req_valid = 2'b01;
        a0 = 32'd9;
        b0 = 32'd9;
        q.push_back('{1'b0, 64'd81});
        tick_s();
        chk("rc_accept", 64'(rq[sel]), 64'h1);
        @(posedge clk);
        #1;
        chk("rc_busy", 64'(bz[sel]), 64'h1);
        rst_n = 1'b0;
        req_valid = 2'b00;
        #1;
        chk("rc_resp_valid", 64'(rv[sel]), 64'h0);
        chk("rc_resp_z", rz[sel], 64'h0);
        chk("rc_busy_cleared", 64'(bz[sel]), 64'h0);
        chk("rc_req_ready", 64'(rq[sel]), 64'h0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) tick_s();
        @(posedge clk);
        #1;
        run_vec(tbl[1], "rc_fresh");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 2, meaning cycles operands are held at the multiplier before the product is captured (legal range 1..8).
REQ-002 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 2, per-requester operation request (bit 0 = requester 0).
REQ-005 SHALL have port req_ready, output, 2, per-requester accept strobe.
REQ-006 SHALL have port req0_a / req0_b, input, 32 each, signed operands of requester 0.
REQ-007 SHALL have port req1_a / req1_b, input, 32 each, signed operands of requester 1.
REQ-008 SHALL have port resp_valid, output, 2, per-requester result valid.
REQ-009 SHALL have port resp_ready, input, 2, per-requester result accept.
REQ-010 SHALL have port resp_z, output, 64, signed product of the granted operands.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-012 SHALL instantiate one mul_32_b as the only multiplier, fed from internal operand registers op_a/op_b, never directly from the request ports.
REQ-013 SHALL implement states IDLE, CALC, DONE.
REQ-014 IDLE: req_ready SHALL be combinationally high for exactly the granted requester when any req_valid bit is set, else 2'b00.
REQ-015 On an IDLE edge with a grant: latch the granted operands into op_a/op_b, latch the grant id, clear cnt, go to CALC.
REQ-016 CALC: cnt SHALL increment every edge; on the edge where cnt == LAT-1, capture the mul_32_b output into resp_z and go to DONE.
REQ-017 resp_valid[id] SHALL rise exactly LAT cycles after the accepting edge; the other bit SHALL remain 0.
REQ-018 DONE: resp_valid[id] and resp_z SHALL hold stable until resp_ready[id] is high on an edge, then return to IDLE.
REQ-019 No new request SHALL be accepted in CALC or DONE, giving a minimum spacing of LAT+2 cycles between accepts.
REQ-020 resp_ready bits of the non-granted requester SHALL be ignored.
REQ-021 Product SHALL be the full 64-bit two's-complement a*b, including a = b = 0x80000000 giving 0x4000000000000000.
REQ-022 Requesters SHALL hold req_valid and operands until req_ready; dropping req_valid before grant withdraws the request with no state change.
REQ-023 resp_z SHALL be 0 whenever resp_valid is 2'b00.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, cnt 0, op_a/op_b 0, resp_z 0, resp_valid 2'b00, busy 0, and round-robin pointer to requester 0.
REQ-025 Reset asserted in CALC or DONE SHALL abort the operation with no response ever issued for it.
REQ-026 After rst_n deasserts, the first accept SHALL be possible on the first clock edge.

Configuration
REQ-027 Macro MUL_ARB_ROUND_ROBIN_EN defined: a pointer SHALL toggle to the non-granted requester after every accept; when both request, the pointed-to requester wins.
REQ-028 MUL_ARB_ROUND_ROBIN_EN undefined: fixed priority, with requester 0 always winning simultaneous requests, and no pointer register.

Verification
REQ-029 Single request: LAT=2, req0 a=7, b=-3 -> req_ready=2'b01 that cycle, resp_valid=2'b01 two cycles later, resp_z=0xFFFFFFFFFFFFFFEB.
REQ-030 Corner operands: a=b=0x80000000 -> 0x4000000000000000; a=b=0xFFFFFFFF -> 0x0000000000000001; a=0, b=0x12345678 -> 0.
REQ-031 Contention, RR_EN defined: both valid continuously -> grants alternate 0,1,0,1, each with its own correct product; undefined -> requester 0 is always granted.
REQ-032 Backpressure: resp_ready low for 5 cycles in DONE -> resp_valid and resp_z hold; req1 asserted meanwhile gets req_ready=0 until the cycle after resp_ready.
REQ-033 Reset mid-CALC: pull rst_n low at cnt=0 with LAT=4 -> all outputs 0 at once, no resp_valid afterwards, and a fresh request after release completes normally.
REQ-034 LAT sweep 1 and 8: resp_valid rises exactly LAT cycles after the accepting edge.
